// File: rtl/xdom_pkg.sv
// Shared constants and offset decode for the xdom register-bank slaves.
// Exports window geometry, fixed register offsets, the unmapped-read pattern,
// the unlock key and a decode helper used by xdom_reg_bank.
package xdom_pkg;

    localparam int unsigned WIN_OFF_W = 7;
    localparam int unsigned WIN_SIZE  = 128;

    localparam logic [WIN_OFF_W-1:0] OFF_STAT_BASE = 7'h40;
    localparam logic [WIN_OFF_W-1:0] OFF_LOCK      = 7'h7B;
    localparam logic [WIN_OFF_W-1:0] OFF_TASK      = 7'h7C;
    localparam logic [WIN_OFF_W-1:0] OFF_ERR       = 7'h7D;
    localparam logic [WIN_OFF_W-1:0] OFF_GEOM      = 7'h7E;

    localparam logic [15:0] UNMAPPED_RD_VAL = 16'hDEAD;
    localparam logic [15:0] LOCK_KEY        = 16'hA5C3;

    // One-hot classification of a window offset.
    typedef struct packed {
        logic ctrl;
        logic stat;
        logic tsk;
        logic err;
        logic geom;
        logic lock;
        logic unmapped;
    } off_dec_t;

    // Classify an in-window offset for the given bank geometry.
    function automatic off_dec_t decode_off(
        input logic [WIN_OFF_W-1:0] off,
        input int unsigned          num_ctrl,
        input int unsigned          num_stat,
        input logic                 lock_en
    );
        off_dec_t d;
        d = '0;
        if (32'(off) < num_ctrl) begin
            d.ctrl = 1'b1;
        end else if ((off >= OFF_STAT_BASE) && (32'(off - OFF_STAT_BASE) < num_stat)) begin
            d.stat = 1'b1;
        end else if (off == OFF_TASK) begin
            d.tsk = 1'b1;
        end else if (off == OFF_ERR) begin
            d.err = 1'b1;
        end else if (off == OFF_GEOM) begin
            d.geom = 1'b1;
        end else if (lock_en && (off == OFF_LOCK)) begin
            d.lock = 1'b1;
        end else begin
            d.unmapped = 1'b1;
        end
        return d;
    endfunction

endpackage

// File: rtl/xdom_pulse_gen.sv
// One-shot pulse generator: pulse is high for exactly PULSE_LEN cycles
// starting the cycle after load; a load while active restarts the count.
// Ports: clk, rst_n (async active-low), load (trigger), pulse (registered).
module xdom_pulse_gen #(
    parameter int unsigned PULSE_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic pulse
);

    // Counter holds the remaining cycles after the current one.
    localparam int unsigned CNT_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            pulse <= 1'b0;
        end else if (load) begin
            cnt   <= CNT_W'(PULSE_LEN - 1);
            pulse <= 1'b1;
        end else if (cnt != '0) begin
            cnt   <= cnt - CNT_W'(1);
        end else begin
            pulse <= 1'b0;
        end
    end

endmodule

// File: rtl/xdom_reg_bank.sv
// Parametrised register-bank slave on the CRS y-bus.
// Window of 128 words at BASE_ADR: ctrl RW regs at 0x00.., status RO at 0x40..,
// task trigger/mask 0x7C, error count 0x7D (write clears), geometry 0x7E.
// Optional macro XDOM_REG_BANK_WR_LOCK_EN adds a write lock at 0x7B guarding
// ctrl and task writes.
// Ports: clk, rst_n; y_adr/y_wr/y_wr_data/y_rd_req bus inputs;
// y_rd_data/y_rd_ack/y_hit registered read response; ctrl_out flattened ctrl
// regs; stat_in flattened status inputs; task_pulse one-shots; err_cnt.
module xdom_reg_bank
    import xdom_pkg::*;
#(
    parameter int unsigned      ADR_W     = 12,
    parameter int unsigned      DATA_W    = 16,
    parameter logic [ADR_W-1:0] BASE_ADR  = ADR_W'(12'h800),
    parameter int unsigned      NUM_CTRL  = 8,
    parameter int unsigned      NUM_STAT  = 4,
    parameter int unsigned      NUM_TASK  = 4,
    parameter int unsigned      PULSE_LEN = 4,
    parameter int unsigned      ERR_W     = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [ADR_W-1:0]             y_adr,
    input  logic                         y_wr,
    input  logic [DATA_W-1:0]            y_wr_data,
    input  logic                         y_rd_req,
    output logic [DATA_W-1:0]            y_rd_data,
    output logic                         y_rd_ack,
    output logic                         y_hit,
    output logic [NUM_CTRL*DATA_W-1:0]   ctrl_out,
    input  logic [NUM_STAT*DATA_W-1:0]   stat_in,
    output logic [NUM_TASK-1:0]          task_pulse,
    output logic [ERR_W-1:0]             err_cnt
);

    localparam logic [16:0] GEOM_RAW =
        {5'(NUM_TASK), 6'(NUM_STAT), 6'(NUM_CTRL)};
    localparam logic [DATA_W-1:0] GEOM_WORD = DATA_W'(GEOM_RAW);
    localparam logic [DATA_W-1:0] UNMAPPED_WORD =
        DATA_W'({((DATA_W + 15) / 16){UNMAPPED_RD_VAL}});

    logic [WIN_OFF_W-1:0] off_c;
    logic                 in_win_c;
    off_dec_t             dec_c;
    logic                 locked_c;
    logic                 wr_hit_c;
    logic                 rd_hit_c;
    logic                 ctrl_we_c;
    logic                 task_we_c;
    logic                 err_clr_c;
    logic                 wr_err_c;
    logic                 rd_err_c;
    logic [DATA_W-1:0]    rd_val_c;

`ifdef XDOM_REG_BANK_WR_LOCK_EN
    localparam logic LOCK_EN = 1'b1;
    logic lock_q;

    // Lock comes up engaged; only the key value releases it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q <= 1'b1;
        end else if (wr_hit_c && dec_c.lock) begin
            lock_q <= (y_wr_data != DATA_W'(LOCK_KEY));
        end
    end

    assign locked_c = lock_q;
`else
    localparam logic LOCK_EN = 1'b0;
    assign locked_c = 1'b0;
`endif

    // Address decode.
    assign off_c    = y_adr[WIN_OFF_W-1:0];
    assign in_win_c = (y_adr[ADR_W-1:WIN_OFF_W] == BASE_ADR[ADR_W-1:WIN_OFF_W]);
    assign dec_c    = decode_off(off_c, NUM_CTRL, NUM_STAT, LOCK_EN);

    assign wr_hit_c  = y_wr & in_win_c;
    assign rd_hit_c  = y_rd_req & in_win_c;
    assign ctrl_we_c = wr_hit_c & dec_c.ctrl & ~locked_c;
    assign task_we_c = wr_hit_c & dec_c.tsk & ~locked_c;
    assign err_clr_c = wr_hit_c & dec_c.err;
    // Any in-window write that is neither accepted nor the clear/lock reg is an error.
    assign wr_err_c  = wr_hit_c & ~(ctrl_we_c | task_we_c | dec_c.err | dec_c.lock);
    assign rd_err_c  = rd_hit_c & dec_c.unmapped;

    // Control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_out <= '0;
        end else if (ctrl_we_c) begin
            for (int unsigned i = 0; i < NUM_CTRL; i++) begin
                if (off_c == WIN_OFF_W'(i)) begin
                    ctrl_out[i*DATA_W +: DATA_W] <= y_wr_data;
                end
            end
        end
    end

    // One pulse generator per task bit.
    for (genvar g = 0; g < int'(NUM_TASK); g++) begin : g_task
        xdom_pulse_gen #(
            .PULSE_LEN (PULSE_LEN)
        ) u_pulse (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (task_we_c & y_wr_data[g]),
            .pulse (task_pulse[g])
        );
    end

    // Saturating error counter; clear beats a same-cycle error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (err_clr_c) begin
            err_cnt <= '0;
        end else if ((wr_err_c || rd_err_c) && (err_cnt != {ERR_W{1'b1}})) begin
            err_cnt <= err_cnt + ERR_W'(1);
        end
    end

    // Read mux; sees pre-write register values.
    always_comb begin
        rd_val_c = '0;
        if (in_win_c) begin
            if (dec_c.ctrl) begin
                for (int unsigned i = 0; i < NUM_CTRL; i++) begin
                    if (off_c == WIN_OFF_W'(i)) begin
                        rd_val_c = ctrl_out[i*DATA_W +: DATA_W];
                    end
                end
            end else if (dec_c.stat) begin
                for (int unsigned i = 0; i < NUM_STAT; i++) begin
                    if (off_c == (OFF_STAT_BASE + WIN_OFF_W'(i))) begin
                        rd_val_c = stat_in[i*DATA_W +: DATA_W];
                    end
                end
            end else if (dec_c.tsk) begin
                rd_val_c = DATA_W'(task_pulse);
            end else if (dec_c.err) begin
                rd_val_c = DATA_W'(err_cnt);
            end else if (dec_c.geom) begin
                rd_val_c = GEOM_WORD;
            end else if (dec_c.lock) begin
                rd_val_c = DATA_W'(locked_c);
            end else begin
                rd_val_c = UNMAPPED_WORD;
            end
        end
    end

    // Registered read response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_rd_data <= '0;
            y_rd_ack  <= 1'b0;
            y_hit     <= 1'b0;
        end else begin
            y_rd_data <= y_rd_req ? rd_val_c : '0;
            y_rd_ack  <= y_rd_req;
            y_hit     <= rd_hit_c;
        end
    end

endmodule

// File: tb/tb_xdom_reg_bank.sv
// Self-checking bench for xdom_reg_bank: directed bus traffic, read responses
// checked by a scoreboard monitor, side-band outputs checked inline.
module tb_xdom_reg_bank;

    localparam int unsigned DW = 16;
    localparam int unsigned NC = 8;
    localparam int unsigned NS = 4;
    localparam int unsigned NT = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [11:0]      y_adr;
    logic             y_wr;
    logic [DW-1:0]    y_wr_data;
    logic             y_rd_req;
    logic [DW-1:0]    y_rd_data;
    logic             y_rd_ack;
    logic             y_hit;
    logic [NC*DW-1:0] ctrl_out;
    logic [NS*DW-1:0] stat_in;
    logic [NT-1:0]    task_pulse;
    logic [7:0]       err_cnt;

    logic [DW-1:0]    y_rd_data2;
    logic             y_rd_ack2;
    logic             y_hit2;
    logic [NC*DW-1:0] ctrl_out2;
    logic [NT-1:0]    task_pulse2;
    logic [1:0]       err_cnt2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          hit;
    } exp_t;

    exp_t       exp_q[$];
    int         n_pass  = 0;
    int         n_total = 0;
    logic [3:0] tp_exp [8];

    always #5 clk = ~clk;

    xdom_reg_bank u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .y_adr      (y_adr),
        .y_wr       (y_wr),
        .y_wr_data  (y_wr_data),
        .y_rd_req   (y_rd_req),
        .y_rd_data  (y_rd_data),
        .y_rd_ack   (y_rd_ack),
        .y_hit      (y_hit),
        .ctrl_out   (ctrl_out),
        .stat_in    (stat_in),
        .task_pulse (task_pulse),
        .err_cnt    (err_cnt)
    );

    // Narrow error counter instance to exercise saturation.
    xdom_reg_bank #(.ERR_W(2)) u_dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .y_adr      (y_adr),
        .y_wr       (y_wr),
        .y_wr_data  (y_wr_data),
        .y_rd_req   (y_rd_req),
        .y_rd_data  (y_rd_data2),
        .y_rd_ack   (y_rd_ack2),
        .y_hit      (y_hit2),
        .ctrl_out   (ctrl_out2),
        .stat_in    (stat_in),
        .task_pulse (task_pulse2),
        .err_cnt    (err_cnt2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] creg(input int unsigned i);
        return ctrl_out[i*DW +: DW];
    endfunction

    // One bus cycle; a read pushes its expected response.
    task automatic bus(input logic [11:0] adr, input logic wr, input logic [DW-1:0] wd,
                       input logic rd, input logic [DW-1:0] ed, input logic eh);
        exp_t e;
        y_adr     = adr;
        y_wr      = wr;
        y_wr_data = wd;
        y_rd_req  = rd;
        if (rd) begin
            e.data = ed;
            e.hit  = eh;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        y_wr     = 1'b0;
        y_rd_req = 1'b0;
    endtask

    task automatic wr(input logic [11:0] adr, input logic [DW-1:0] d);
        bus(adr, 1'b1, d, 1'b0, '0, 1'b0);
    endtask

    task automatic rd(input logic [11:0] adr, input logic [DW-1:0] ed, input logic eh);
        bus(adr, 1'b0, '0, 1'b1, ed, eh);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Read-response monitor.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (y_rd_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL rd_ack_unexpected: got ack with data 0x%0h, expected no ack", y_rd_data);
            end else begin
                e = exp_q.pop_front();
                check("rd_data", 32'(y_rd_data), 32'(e.data));
                check("rd_hit", 32'(y_hit), 32'(e.hit));
            end
        end
    end

    initial begin
        tp_exp    = '{4'h5, 4'h5, 4'h5, 4'h5, 4'h1, 4'h1, 4'h1, 4'h0};
        rst_n     = 1'b0;
        y_adr     = '0;
        y_wr      = 1'b0;
        y_wr_data = '0;
        y_rd_req  = 1'b0;
        stat_in   = {16'h4444, 16'h3333, 16'hBEEF, 16'h1111};
        idle(2);

        // Reset state.
        check("rst_ctrl", 32'(ctrl_out != '0), 32'h0);
        check("rst_task", 32'(task_pulse), 32'h0);
        check("rst_err", 32'(err_cnt), 32'h0);
        check("rst_ack", 32'(y_rd_ack), 32'h0);
        rst_n = 1'b1;
        idle(1);

`ifdef XDOM_REG_BANK_WR_LOCK_EN
        wr(12'h800, 16'h0011);
        check("lock_ctrl_dropped", 32'(creg(0)), 32'h0);
        check("lock_err1", 32'(err_cnt), 32'h1);
        wr(12'h87C, 16'h0001);
        check("lock_task_dropped", 32'(task_pulse), 32'h0);
        check("lock_err2", 32'(err_cnt), 32'h2);
        rd(12'h87B, 16'h0001, 1'b1);
        wr(12'h87B, 16'hA5C3);
        rd(12'h87B, 16'h0000, 1'b1);
        wr(12'h800, 16'h0011);
        check("unlock_ctrl", 32'(creg(0)), 32'h11);
        wr(12'h87B, 16'h0000);
        rd(12'h87B, 16'h0001, 1'b1);
        wr(12'h87B, 16'hA5C3);
        wr(12'h87D, 16'h0000);
        check("lock_err_clr", 32'(err_cnt), 32'h0);
`endif

        // Ctrl round trip and read-before-write.
        wr(12'h803, 16'h00AB);
        check("ctrl3_wr", 32'(creg(3)), 32'hAB);
        rd(12'h803, 16'h00AB, 1'b1);
        bus(12'h803, 1'b1, 16'h0055, 1'b1, 16'h00AB, 1'b1);
        check("ctrl3_rw", 32'(creg(3)), 32'h55);
        rd(12'h803, 16'h0055, 1'b1);
        wr(12'h807, 16'h7777);
        rd(12'h807, 16'h7777, 1'b1);
        check("err_after_ctrl", 32'(err_cnt), 32'h0);

        // Task pulses with a reload on bit 0 at cycle 3.
        wr(12'h87C, 16'h0005);
        for (int c = 1; c <= 8; c++) begin
            check($sformatf("task_c%0d", c), 32'(task_pulse), 32'(tp_exp[c-1]));
            if (c == 3) begin
                wr(12'h87C, 16'h0001);
            end else if (c == 5) begin
                rd(12'h87C, 16'h0001, 1'b1);
            end else begin
                idle(1);
            end
        end

        // Error counting and saturation (ERR_W=2 instance saturates at 3).
        wr(12'h840, 16'h0001);
        rd(12'h850, 16'hDEAD, 1'b1);
        check("err_2", 32'(err_cnt), 32'h2);
        check("err2_2", 32'(err_cnt2), 32'h2);
        rd(12'h808, 16'hDEAD, 1'b1);
        wr(12'h87E, 16'hFFFF);
        check("err_4", 32'(err_cnt), 32'h4);
        check("err2_sat", 32'(err_cnt2), 32'h3);
        bus(12'h870, 1'b1, 16'h0000, 1'b1, 16'hDEAD, 1'b1);
        check("err_dual_once", 32'(err_cnt), 32'h5);
        check("err2_still_sat", 32'(err_cnt2), 32'h3);
        bus(12'h87D, 1'b1, 16'h0000, 1'b1, 16'h0005, 1'b1);
        check("err_clr", 32'(err_cnt), 32'h0);
        check("err2_clr", 32'(err_cnt2), 32'h0);

        // Status, window edges, geometry; reads issued back-to-back.
        rd(12'h841, 16'hBEEF, 1'b1);
        rd(12'h843, 16'h4444, 1'b1);
        rd(12'h844, 16'hDEAD, 1'b1);
        rd(12'h880, 16'h0000, 1'b0);
        rd(12'h7FF, 16'h0000, 1'b0);
        rd(12'h87E, 16'h4108, 1'b1);
        rd(12'h87D, 16'h0001, 1'b1);
        check("err_out_of_win", 32'(err_cnt), 32'h1);
        wr(12'h903, 16'hFFFF);
        check("oow_wr_ignored", 32'(creg(3)), 32'h55);
        check("oow_wr_no_err", 32'(err_cnt), 32'h1);
        wr(12'h87D, 16'h1234);
        check("err_clr2", 32'(err_cnt), 32'h0);

        // Asynchronous reset mid-operation.
        wr(12'h800, 16'h1234);
        check("ctrl0_pre_rst", 32'(creg(0)), 32'h1234);
        wr(12'h87C, 16'h000F);
        wr(12'h860, 16'h0000);
        check("task_pre_rst", 32'(task_pulse), 32'hF);
        check("err_pre_rst", 32'(err_cnt), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ctrl0", 32'(creg(0)), 32'h0);
        check("arst_task", 32'(task_pulse), 32'h0);
        check("arst_err", 32'(err_cnt), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
        check("post_rst_task", 32'(task_pulse), 32'h0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
